// File: rtl/sdram_cycle_sequencer_if.sv
// rtl/sdram_cycle_sequencer_if.sv - CPU-side and controller-side signal bundle for the SDRAM cycle sequencer
//
// Purpose: groups the CPU request/response handshake and the SDRAM controller slot bus.
// Ports (slave = sequencer view):
//   cpu_req, cpu_we, cpu_addr[23:0], cpu_wdata[15:0]  CPU request, level-held until cpu_ack
//   cpu_rdata[15:0], cpu_ack                          read data and one-cycle completion pulse
//   busy                                              slot in progress or still in init
//   as, nwr, ad[23:0], din[15:0]                      controller slot start, write strobe, address, data
//   dout[15:0]                                        controller read data
interface sdram_cycle_sequencer_if;
   logic        cpu_req;
   logic        cpu_we;
   logic [23:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_ack;
   logic        busy;
   logic        as;
   logic        nwr;
   logic [23:0] ad;
   logic [15:0] din;
   logic [15:0] dout;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dout,
      output cpu_rdata, cpu_ack, busy, as, nwr, ad, din
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, dout,
      input  cpu_rdata, cpu_ack, busy, as, nwr, ad, din
   );
endinterface

// File: rtl/sdram_cycle_sequencer.sv
// rtl/sdram_cycle_sequencer.sv - slot sequencer in front of the TMS99000 SDRAM controller
//
// Purpose: turns level-held CPU requests into fixed-length controller slots, returns read
// data with a one-cycle ack, inserts dummy read slots while idle so auto-refresh keeps
// running, and holds off all slots until the controller power-up init has completed.
// Ports:
//   clk_in  controller clock
//   rst     asynchronous reset, active high
//   bus     sdram_cycle_sequencer_if.slave (CPU handshake + controller slot bus)
// Configuration macro: SDRAM_SEQ_POSTWR_EN - when defined, writes are acked in the cycle
// after their as cycle (posted); reads are unaffected.
module sdram_cycle_sequencer #(
   parameter int SLOT_CYCLES      = 18,
   parameter int RDATA_CYCLE      = 9,
   parameter int REFRESH_INTERVAL = 900,
   parameter int INIT_CYCLES      = 32
) (
   input  logic                     clk_in,
   input  logic                     rst,
   sdram_cycle_sequencer_if.slave   bus
);
   localparam int INIT_W = $clog2(INIT_CYCLES + 1);
   localparam int SLOT_W = $clog2(SLOT_CYCLES + 1);
   localparam int RFSH_W = $clog2(REFRESH_INTERVAL + 1);

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SLOT} state_t;

   state_t              state;
   state_t              state_next;
   logic [INIT_W-1:0]   init_cnt;
   logic [SLOT_W-1:0]   slot_cnt;
   logic [RFSH_W-1:0]   rfsh_cnt;
   logic                slot_real;
   logic [23:0]         ad_q;
   logic [15:0]         din_q;
   logic                nwr_q;
   logic [15:0]         rdata_q;
   logic                start_slot;
   logic                start_real;
   logic                slot_last;
   logic                init_done;
   logic                rfsh_due;

   assign slot_last = (slot_cnt == SLOT_W'(SLOT_CYCLES - 1));
   assign init_done = (init_cnt == INIT_W'(INIT_CYCLES - 1));
   assign rfsh_due  = (rfsh_cnt == RFSH_W'(REFRESH_INTERVAL));

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state     <= ST_INIT;
         init_cnt  <= '0;
         slot_cnt  <= '0;
         rfsh_cnt  <= '0;
         slot_real <= 1'b0;
         ad_q      <= '0;
         din_q     <= '0;
         nwr_q     <= 1'b1;
         rdata_q   <= '0;
      end else begin
         state <= state_next;

         if (state == ST_INIT && !init_done)
            init_cnt <= init_cnt + INIT_W'(1);

         // Counts every cycle since the last slot start, so an idle bus sees one
         // dummy slot every REFRESH_INTERVAL+1 cycles.
         if (start_slot)
            rfsh_cnt <= '0;
         else if (state != ST_INIT && !rfsh_due)
            rfsh_cnt <= rfsh_cnt + RFSH_W'(1);

         if (start_slot) begin
            slot_cnt  <= '0;
            slot_real <= start_real;
            if (start_real) begin
               ad_q  <= bus.cpu_addr;
               din_q <= bus.cpu_wdata;
               nwr_q <= ~bus.cpu_we;
            end else begin
               // Dummy slot: a read at whatever address is already on ad.
               nwr_q <= 1'b1;
            end
         end else if (state == ST_SLOT && !slot_last) begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
         end

         if (state == ST_SLOT && slot_real && nwr_q && slot_cnt == SLOT_W'(RDATA_CYCLE))
            rdata_q <= bus.dout;
      end
   end

   always_comb begin
      state_next  = state;
      start_slot  = 1'b0;
      start_real  = 1'b0;
      bus.as      = 1'b0;
      bus.cpu_ack = 1'b0;
      bus.busy    = 1'b1;
      case (state)
         ST_INIT: begin
            if (init_done)
               state_next = ST_IDLE;
         end
         ST_IDLE: begin
            bus.busy = 1'b0;
            // A CPU slot also refreshes, so it takes priority over a due dummy slot.
            if (bus.cpu_req) begin
               start_slot = 1'b1;
               start_real = 1'b1;
               state_next = ST_SLOT;
            end else if (rfsh_due) begin
               start_slot = 1'b1;
               state_next = ST_SLOT;
            end
         end
         ST_SLOT: begin
            bus.as = (slot_cnt == '0);
`ifdef SDRAM_SEQ_POSTWR_EN
            bus.cpu_ack = slot_real &&
                          ((!nwr_q && slot_cnt == SLOT_W'(1)) || (nwr_q && slot_last));
`else
            bus.cpu_ack = slot_real && slot_last;
`endif
            if (slot_last)
               state_next = ST_IDLE;
         end
         default: state_next = ST_INIT;
      endcase
   end

   assign bus.ad        = ad_q;
   assign bus.din       = din_q;
   assign bus.nwr       = nwr_q;
   assign bus.cpu_rdata = rdata_q;
endmodule
